// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: CP0 interrupt controller for the single-cycle MIPS datapath.
// Latches NUM_IRQ interrupt lines (edge or level per channel), applies the
// Status mask/enable, picks the lowest-index pending channel, saves EPC,
// redirects the PC to EXC_VECTOR and restores IE on rfe. Serves mfc0/mtc0.
//
// Ports:
//   clk, reset   processor clock, async active-high reset
//   hwint        interrupt requests, synchronous to clk
//   pc_next      PC the current instruction would go to next (saved to EPC)
//   mtc0_we/sel/wdata   CP0 write port
//   mfc0_sel/rdata      CP0 read port (combinational)
//   rfe          return-from-exception strobe
//   exc_take     redirect PC to exc_vector this cycle (combinational)
//   exc_vector   constant EXC_VECTOR
//   epc_out      saved EPC, PC target on rfe
//   in_service   high while an interrupt is being serviced
module cp0_irq_ctrl #(
    parameter int unsigned         NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0]  EDGE_MASK  = {NUM_IRQ{1'b1}},
    parameter logic [31:0]         EXC_VECTOR = 32'h0000_0180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] hwint,
    input  logic [31:0]        pc_next,
    input  logic               mtc0_we,
    input  logic [4:0]         mtc0_sel,
    input  logic [31:0]        mtc0_wdata,
    input  logic [4:0]         mfc0_sel,
    output logic [31:0]        mfc0_rdata,
    input  logic               rfe,
    output logic               exc_take,
    output logic [31:0]        exc_vector,
    output logic [31:0]        epc_out,
    output logic               in_service
);

    localparam logic [4:0]  SEL_STATUS = 5'd12;
    localparam logic [4:0]  SEL_CAUSE  = 5'd13;
    localparam logic [4:0]  SEL_EPC    = 5'd14;
    localparam logic [4:0]  SEL_COUNT  = 5'd15;
    localparam int unsigned IM_LSB     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ISR  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_IRQ-1:0] hwint_q;
    logic [NUM_IRQ-1:0] ip;
    logic [NUM_IRQ-1:0] ip_next;
    logic [NUM_IRQ-1:0] im;
    logic               ie;
    logic               iep;
    logic [2:0]         code;
    logic [31:0]        epc;
    logic [31:0]        count;

    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] rise;
    logic [2:0]         winner;
    logic               wr_status;
    logic               wr_cause;
    logic               wr_epc;

    assign wr_status = mtc0_we && (mtc0_sel == SEL_STATUS);
    assign wr_cause  = mtc0_we && (mtc0_sel == SEL_CAUSE);
    assign wr_epc    = mtc0_we && (mtc0_sel == SEL_EPC);

    assign req      = ip & im;
    assign exc_take = ie && (|req) && (state == IDLE) && !rfe;

    assign exc_vector = EXC_VECTOR;
    assign epc_out    = epc;
    assign in_service = (state == ISR);

    // Edge channels: set on rising edge, W1C clears, a same-cycle set wins.
    // Level channels simply follow the line and ignore W1C.
    assign w1c     = wr_cause ? mtc0_wdata[IM_LSB +: NUM_IRQ] : '0;
    assign rise    = hwint & ~hwint_q;
    assign ip_next = (EDGE_MASK & ((ip & ~w1c) | rise)) | (~EDGE_MASK & hwint);

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; rfe and take are mutually exclusive by construction.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (exc_take) state_next = ISR;
            ISR:     if (rfe)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pending bits and line history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hwint_q <= '0;
            ip      <= '0;
        end else begin
            hwint_q <= hwint;
            ip      <= ip_next;
        end
    end

    // Status: take beats rfe beats software for IE; IM always follows mtc0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie  <= 1'b0;
            iep <= 1'b0;
            im  <= '0;
        end else begin
            if (wr_status) begin
                im <= mtc0_wdata[IM_LSB +: NUM_IRQ];
            end
            if (exc_take) begin
                iep <= ie;
                ie  <= 1'b0;
            end else if (rfe) begin
                ie <= iep;
            end else if (wr_status) begin
                ie <= mtc0_wdata[0];
            end
        end
    end

    // EPC, cause code and taken-interrupt counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc   <= '0;
            code  <= '0;
            count <= '0;
        end else begin
            if (exc_take) begin
                epc   <= pc_next;
                code  <= winner;
                count <= count + 32'd1;
            end else if (wr_epc) begin
                epc <= mtc0_wdata;
            end
        end
    end

    // CP0 read mux; unmapped registers read as zero.
    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_sel)
            SEL_STATUS: begin
                mfc0_rdata[0]                  = ie;
                mfc0_rdata[1]                  = iep;
                mfc0_rdata[IM_LSB +: NUM_IRQ]  = im;
            end
            SEL_CAUSE: begin
                mfc0_rdata[4:2]                = code;
                mfc0_rdata[IM_LSB +: NUM_IRQ]  = ip;
            end
            SEL_EPC:   mfc0_rdata = epc;
            SEL_COUNT: mfc0_rdata = count;
            default:   mfc0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Testbench for cp0_irq_ctrl: a cycle table drives the default (all-edge)
// instance through take/rfe/mask/priority sequences; hand-written sequences
// cover reset, level-channel behaviour and reset in the middle of an ISR.
module tb_cp0_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  hwint;
    logic [31:0] pc_next;
    logic        mtc0_we;
    logic [4:0]  mtc0_sel;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_sel;
    logic        rfe;
    logic [31:0] mfc0_rdata, mfc0_rdata_lv;
    logic        exc_take, exc_take_lv;
    logic [31:0] exc_vector, exc_vector_lv;
    logic [31:0] epc_out, epc_out_lv;
    logic        in_service, in_service_lv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cp0_irq_ctrl dut (
        .clk(clk), .reset(reset), .hwint(hwint), .pc_next(pc_next),
        .mtc0_we(mtc0_we), .mtc0_sel(mtc0_sel), .mtc0_wdata(mtc0_wdata),
        .mfc0_sel(mfc0_sel), .mfc0_rdata(mfc0_rdata), .rfe(rfe),
        .exc_take(exc_take), .exc_vector(exc_vector), .epc_out(epc_out),
        .in_service(in_service)
    );

    // Channel 0 level-sensitive, the rest edge-sensitive.
    cp0_irq_ctrl #(.NUM_IRQ(4), .EDGE_MASK(4'b1110)) dut_lv (
        .clk(clk), .reset(reset), .hwint(hwint), .pc_next(pc_next),
        .mtc0_we(mtc0_we), .mtc0_sel(mtc0_sel), .mtc0_wdata(mtc0_wdata),
        .mfc0_sel(mfc0_sel), .mfc0_rdata(mfc0_rdata_lv), .rfe(rfe),
        .exc_take(exc_take_lv), .exc_vector(exc_vector_lv), .epc_out(epc_out_lv),
        .in_service(in_service_lv)
    );

    typedef struct {
        logic [3:0]  hw;
        logic        we;
        logic [4:0]  wsel;
        logic [31:0] wdata;
        logic        rfe;
        logic [31:0] pc;
        logic [4:0]  rsel;
        logic        take;
        logic [31:0] rdata;
        logic        isr;
    } vec_t;

    typedef struct {
        int          idx;
        logic        take;
        logic [31:0] rdata;
        logic        isr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic [3:0] hw, logic we, logic [4:0] wsel,
                                logic [31:0] wdata, logic r, logic [31:0] pc,
                                logic [4:0] rsel, logic take, logic [31:0] rdata,
                                logic isr);
        vec_t v;
        v.hw = hw; v.we = we; v.wsel = wsel; v.wdata = wdata; v.rfe = r;
        v.pc = pc; v.rsel = rsel; v.take = take; v.rdata = rdata; v.isr = isr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        hwint = '0; pc_next = '0; mtc0_we = 1'b0; mtc0_sel = '0;
        mtc0_wdata = '0; mfc0_sel = '0; rfe = 1'b0;
    endtask

    // Drive one table row at the negedge, queue its expectation, then
    // sample the combinational outputs 1 time unit later.
    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        hwint = v.hw; mtc0_we = v.we; mtc0_sel = v.wsel; mtc0_wdata = v.wdata;
        rfe = v.rfe; pc_next = v.pc; mfc0_sel = v.rsel;
        e.idx = idx; e.take = v.take; e.rdata = v.rdata; e.isr = v.isr;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        chk($sformatf("vec%0d exc_take", got.idx), 32'(exc_take), 32'(got.take));
        chk($sformatf("vec%0d mfc0_rdata", got.idx), mfc0_rdata, got.rdata);
        chk($sformatf("vec%0d in_service", got.idx), 32'(in_service), 32'(got.isr));
    endtask

    localparam logic [4:0] ST = 5'd12, CA = 5'd13, EP = 5'd14, CN = 5'd15;

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        // Outputs during reset.
        mfc0_sel = ST;
        #1;
        chk("reset exc_take", 32'(exc_take), 32'd0);
        chk("reset in_service", 32'(in_service), 32'd0);
        chk("reset epc_out", epc_out, 32'd0);
        chk("reset exc_vector", exc_vector, 32'h0000_0180);
        chk("reset status", mfc0_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //            hw     we   wsel wdata        rfe pc       rsel take rdata        isr
        // Test 1: IM=1111, IE=1, pulse ch2.
        vecs.push_back(mk(4'b0000, 1, ST, 32'h0F01, 0, 32'h0,   ST, 0, 32'h0,    0));
        vecs.push_back(mk(4'b0100, 0, 0,  32'h0,    0, 32'h0,   ST, 0, 32'h0F01, 0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h40,  CA, 1, 32'h400,  0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   EP, 0, 32'h40,   1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CA, 0, 32'h408,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CN, 0, 32'h1,    1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   ST, 0, 32'h0F02, 1));
        vecs.push_back(mk(4'b0000, 1, CA, 32'h400,  1, 32'h0,   CA, 0, 32'h408,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   ST, 0, 32'h0F03, 0));
        // Test 2: ch1 and ch3 together, ch1 wins; ch3 after W1C + rfe.
        vecs.push_back(mk(4'b1010, 0, 0,  32'h0,    0, 32'h0,   CA, 0, 32'h008,  0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h80,  CA, 1, 32'hA08,  0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CA, 0, 32'hA04,  1));
        vecs.push_back(mk(4'b0000, 1, CA, 32'h200,  1, 32'hC0,  EP, 0, 32'h80,   1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'hC0,  CA, 1, 32'h804,  0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CA, 0, 32'h80C,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CN, 0, 32'h3,    1));
        vecs.push_back(mk(4'b0000, 1, CA, 32'h800,  1, 32'h0,   EP, 0, 32'hC0,   1));
        // Test 3: masked request waits until IM enables it.
        vecs.push_back(mk(4'b0000, 1, ST, 32'h0101, 0, 32'h0,   ST, 0, 32'h0F03, 0));
        vecs.push_back(mk(4'b0010, 0, 0,  32'h0,    0, 32'h0,   ST, 0, 32'h0103, 0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CA, 0, 32'h20C,  0));
        vecs.push_back(mk(4'b0000, 1, ST, 32'h0201, 0, 32'h0,   CA, 0, 32'h20C,  0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h100, ST, 1, 32'h0203, 0));
        // Test 5: IE set inside ISR does not nest; take follows rfe.
        vecs.push_back(mk(4'b0000, 1, ST, 32'h0201, 0, 32'h0,   CA, 0, 32'h204,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   ST, 0, 32'h0203, 1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    1, 32'h0,   CA, 0, 32'h204,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h140, ST, 1, 32'h0203, 0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   EP, 0, 32'h140,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CN, 0, 32'h5,    1));
        vecs.push_back(mk(4'b0000, 1, CA, 32'h200,  1, 32'h0,   ST, 0, 32'h0202, 1));
        // Take overrides a same-cycle EPC write; EPC writable; unmapped regs.
        vecs.push_back(mk(4'b0010, 0, 0,  32'h0,    0, 32'h0,   ST, 0, 32'h0203, 0));
        vecs.push_back(mk(4'b0000, 1, EP, 32'hDEAD, 0, 32'h180, EP, 1, 32'h140,  0));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   EP, 0, 32'h180,  1));
        vecs.push_back(mk(4'b0000, 1, EP, 32'h1234, 0, 32'h0,   5'd31, 0, 32'h0, 1));
        vecs.push_back(mk(4'b0000, 1, 5'd16, 32'hFFFF_FFFF, 0, 32'h0, EP, 0, 32'h1234, 1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   ST, 0, 32'h0202, 1));
        // Edge set and W1C in the same cycle: set wins.
        vecs.push_back(mk(4'b0010, 1, CA, 32'h200,  0, 32'h0,   CA, 0, 32'h204,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CA, 0, 32'h204,  1));
        vecs.push_back(mk(4'b0000, 1, CA, 32'h200,  1, 32'h0,   CA, 0, 32'h204,  1));
        vecs.push_back(mk(4'b0000, 0, 0,  32'h0,    0, 32'h0,   CA, 0, 32'h004,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Reset while in ISR clears everything immediately.
        @(negedge clk);
        idle_inputs();
        hwint = 4'b0010;
        @(negedge clk);
        hwint = 4'b0000; pc_next = 32'h200;
        #1;
        chk("pre-reset take", 32'(exc_take), 32'd1);
        @(negedge clk);
        pc_next = 32'h0;
        #1;
        chk("pre-reset in_service", 32'(in_service), 32'd1);
        chk("pre-reset epc_out", epc_out, 32'h200);
        reset = 1'b1;
        hwint = 4'b0001;
        mfc0_sel = CN;
        #1;
        chk("mid-isr reset exc_take", 32'(exc_take), 32'd0);
        chk("mid-isr reset in_service", 32'(in_service), 32'd0);
        chk("mid-isr reset epc_out", epc_out, 32'd0);
        chk("mid-isr reset count", mfc0_rdata, 32'd0);
        mfc0_sel = ST;
        #1;
        chk("mid-isr reset status", mfc0_rdata, 32'd0);

        // Test 4: edge line high at release sets IP on the first clock;
        // level channel ignores W1C and follows the line.
        @(negedge clk);
        reset = 1'b0;
        mfc0_sel = CA;
        @(negedge clk);
        #1;
        chk("edge ip after release", mfc0_rdata, 32'h100);
        chk("level ip after release", mfc0_rdata_lv, 32'h100);
        mtc0_we = 1'b1; mtc0_sel = CA; mtc0_wdata = 32'h100;
        @(negedge clk);
        mtc0_we = 1'b0;
        #1;
        chk("edge ip after w1c", mfc0_rdata, 32'h000);
        chk("level ip after w1c", mfc0_rdata_lv, 32'h100);
        hwint = 4'b0000;
        @(negedge clk);
        #1;
        chk("level ip after drop", mfc0_rdata_lv, 32'h000);
        chk("level exc_vector", exc_vector_lv, 32'h0000_0180);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
